axi4_mem_master: RTL and testbench

//  Parametrised AXI4 master bridge for the npc core: arbitrates IFU fetch and LSU load/store onto the io_master_* bus.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 36 +++
 rtl/axi4_mem_master.sv | 217 +++++++++++++++++++++
 tb/tb_axi4_mem_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, master FSM states and the size-to-strobe helper
// for the npc memory master.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

  // Byte-enable pattern for an access of 1<<size bytes, right-justified.
  function automatic logic [7:0] size_strobe(input logic [2:0] size);
    case (size)
      3'd0:    size_strobe = 8'h01;
      3'd1:    size_strobe = 8'h03;
      3'd2:    size_strobe = 8'h0F;
      3'd3:    size_strobe = 8'hFF;
      default: size_strobe = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for LSU accesses: store data/strobe shift, load data
// shift and misalignment detection. Purely combinational.
module mem_lane_align import axi_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          addr_lo,
  input  logic [2:0]          size,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W-1:0]   rdata_in,
  output logic [DATA_W-1:0]   wdata_out,
  output logic [DATA_W/8-1:0] wstrb_out,
  output logic [DATA_W-1:0]   rdata_out,
  output logic                misaligned
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] bit_off;
  logic [7:0]       strb8;
  logic [7:0]       amask;

  // Sizes wider than the bus are reported as misaligned so they never reach it.
  always_comb begin
    off        = addr_lo[OFF_W-1:0];
    bit_off    = {off, 3'b000};
    strb8      = size_strobe(size);
    amask      = (8'd1 << size) - 8'd1;
    wdata_out  = wdata_in << bit_off;
    wstrb_out  = STRB_W'(strb8) << off;
    rdata_out  = rdata_in >> bit_off;
    misaligned = (|(addr_lo & amask[2:0])) || (size > 3'(OFF_W));
  end

endmodule

// File: rtl/axi4_mem_master.sv
// AXI4 master bridge arbitrating IFU burst fetches and LSU loads/stores.
// Define ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module axi4_mem_master import axi_pkg::*; #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] IFU_ID  = 4'h0,
  parameter logic [3:0] LSU_ID  = 4'h1,
  parameter logic [7:0] MAX_LEN = 8'd15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  input  logic [7:0]          ifu_req_len,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_last,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_wen,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [2:0]          lsu_req_size,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                lsu_rsp_err,
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid
);

  localparam logic [2:0] BUS_SIZE = 3'($clog2(DATA_W / 8));

  state_t              state, state_nx;
  logic                owner_lsu;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q, beat_cnt;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_done, w_done, mis_pulse;
  logic                lsu_wins, accept_ifu, accept_lsu, rd_beat, beat_last;
  logic                aw_hs, w_hs, idle;
  logic [3:0]          cur_id;
  logic [DATA_W-1:0]   al_wdata, al_rdata;
  logic [DATA_W/8-1:0] al_wstrb;
  logic                al_mis;

`ifdef ARB_RR_EN
  logic rr_lsu;
  assign lsu_wins = rr_lsu;

  // Pointer moves to whichever requester was not just granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           rr_lsu <= 1'b0;
    else if (accept_ifu) rr_lsu <= 1'b1;
    else if (accept_lsu) rr_lsu <= 1'b0;
  end
`else
  assign lsu_wins = 1'b1;
`endif

  // In IDLE the aligner looks at the incoming request so misalignment is caught at accept.
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo    (idle ? lsu_req_addr[2:0] : addr_q[2:0]),
    .size       (idle ? lsu_req_size : size_q),
    .wdata_in   (wdata_q),
    .rdata_in   (io_master_rdata),
    .wdata_out  (al_wdata),
    .wstrb_out  (al_wstrb),
    .rdata_out  (al_rdata),
    .misaligned (al_mis)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      wdata_q   <= '0;
      beat_cnt  <= 8'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      mis_pulse <= 1'b0;
    end else begin
      mis_pulse <= accept_lsu && al_mis;
      if (accept_ifu) begin
        owner_lsu <= 1'b0;
        addr_q    <= ifu_req_addr;
        len_q     <= (ifu_req_len > MAX_LEN) ? MAX_LEN : ifu_req_len;
        size_q    <= BUS_SIZE;
        beat_cnt  <= 8'd0;
      end else if (accept_lsu) begin
        owner_lsu <= 1'b1;
        addr_q    <= lsu_req_addr;
        len_q     <= 8'd0;
        size_q    <= lsu_req_size;
        wdata_q   <= lsu_req_wdata;
        beat_cnt  <= 8'd0;
      end
      if (rd_beat) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
      if (state == WR_AW) begin
        if (state_nx == WR_B) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
        end
      end
    end
  end

  // Readies are masked during reset; with both valid only the winner sees ready.
  always_comb begin
    state_nx          = state;
    idle              = (state == IDLE);
    cur_id            = owner_lsu ? LSU_ID : IFU_ID;
    beat_last         = (beat_cnt == len_q);
    ifu_req_ready     = idle && !reset && !(lsu_req_valid && lsu_wins);
    lsu_req_ready     = idle && !reset && !(ifu_req_valid && !lsu_wins);
    accept_ifu        = ifu_req_valid && ifu_req_ready;
    accept_lsu        = lsu_req_valid && lsu_req_ready;
    io_master_arvalid = (state == RD_A);
    io_master_araddr  = addr_q;
    io_master_arid    = cur_id;
    io_master_arlen   = len_q;
    io_master_arsize  = size_q;
    io_master_arburst = BURST_INCR;
    io_master_rready  = (state == RD_D);
    io_master_awvalid = (state == WR_AW) && !aw_done;
    io_master_wvalid  = (state == WR_AW) && !w_done;
    io_master_awaddr  = addr_q;
    io_master_awid    = LSU_ID;
    io_master_awlen   = 8'd0;
    io_master_awsize  = size_q;
    io_master_awburst = BURST_INCR;
    io_master_wdata   = al_wdata;
    io_master_wstrb   = al_wstrb;
    io_master_wlast   = 1'b1;
    io_master_bready  = (state == WR_B);
    aw_hs             = io_master_awvalid && io_master_awready;
    w_hs              = io_master_wvalid && io_master_wready;
    rd_beat           = (state == RD_D) && io_master_rvalid;
    ifu_rsp_valid     = rd_beat && !owner_lsu;
    ifu_rsp_data      = '0;
    ifu_rsp_last      = 1'b0;
    ifu_rsp_err       = 1'b0;
    lsu_rsp_valid     = 1'b0;
    lsu_rsp_rdata     = '0;
    lsu_rsp_err       = 1'b0;

    if (ifu_rsp_valid) begin
      ifu_rsp_data = io_master_rdata;
      ifu_rsp_last = beat_last;
      ifu_rsp_err  = (io_master_rresp != RESP_OKAY) || (io_master_rlast != beat_last)
                     || (io_master_rid != cur_id);
    end
    if (rd_beat && owner_lsu) begin
      lsu_rsp_valid = 1'b1;
      lsu_rsp_rdata = al_rdata;
      lsu_rsp_err   = (io_master_rresp != RESP_OKAY) || (io_master_rid != cur_id);
    end else if ((state == WR_B) && io_master_bvalid) begin
      lsu_rsp_valid = 1'b1;
      lsu_rsp_err   = (io_master_bresp != RESP_OKAY) || (io_master_bid != LSU_ID);
    end else if (mis_pulse) begin
      lsu_rsp_valid = 1'b1;
      lsu_rsp_err   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept_ifu)                  state_nx = RD_A;
        else if (accept_lsu && !al_mis)  state_nx = lsu_req_wen ? WR_AW : RD_A;
      end
      RD_A:  if (io_master_arready) state_nx = RD_D;
      RD_D:  if (rd_beat && beat_last) state_nx = IDLE;
      WR_AW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_B;
      WR_B:  if (io_master_bvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_mem_master.sv
// Scoreboard bench for axi4_mem_master: directed requests push expected
// responses, a negedge monitor pops and compares every rsp pulse.
module tb_axi4_mem_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic [7:0]  ifu_req_len;
  logic        ifu_rsp_valid, ifu_rsp_last, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [2:0]  lsu_req_size;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t ifu_q[$];
  exp_t lsu_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  axi4_mem_master dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_req_len(ifu_req_len),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_last(ifu_rsp_last), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_size(lsu_req_size), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready),
    .io_master_awaddr(awaddr), .io_master_awid(awid),
    .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready),
    .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready),
    .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready),
    .io_master_araddr(araddr), .io_master_arid(arid),
    .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready),
    .io_master_rdata(rdata), .io_master_rresp(rresp),
    .io_master_rlast(rlast), .io_master_rid(rid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (ifu_rsp_valid) begin
      if (ifu_q.size() == 0) checkOutput("ifu_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = ifu_q.pop_front();
        checkOutput("ifu_data", ifu_rsp_data, e.data);
        checkOutput("ifu_last", ifu_rsp_last, e.last);
        checkOutput("ifu_err", ifu_rsp_err, e.err);
      end
    end
    if (lsu_rsp_valid) begin
      if (lsu_q.size() == 0) checkOutput("lsu_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = lsu_q.pop_front();
        if (e.chk_data) checkOutput("lsu_rdata", lsu_rsp_rdata, e.data);
        checkOutput("lsu_err", lsu_rsp_err, e.err);
        if (e.cyc >= 0) checkOutput("lsu_rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit is_lsu, input logic wen, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [31:0] wd, output int acc);
    bit got = 0;
    acc = -1;
    if (is_lsu) begin
      lsu_req_valid = 1; lsu_req_wen = wen; lsu_req_addr = addr;
      lsu_req_size = size; lsu_req_wdata = wd;
    end else begin
      ifu_req_valid = 1; ifu_req_addr = addr; ifu_req_len = len;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
        got = 1;
        acc = cyc;
      end
      tick();
    end
    if (!got) checkOutput("req_accept_timeout", 64'd0, 64'd1);
    ifu_req_valid = 0;
    lsu_req_valid = 0;
  endtask

  task automatic slave_read(input int nbeats, input int gap, input logic [31:0] base,
                            input int err_beat, input int last_at, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len, input logic [2:0] exp_size,
                            input logic [3:0] exp_id);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (arvalid) seen = 1;
      else tick();
    end
    if (!seen) begin
      checkOutput("arvalid_timeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("araddr", araddr, exp_addr);
    checkOutput("arlen", arlen, exp_len);
    checkOutput("arsize", arsize, exp_size);
    checkOutput("arid_burst", {arid, arburst}, {exp_id, 2'b01});
    tick();
    for (int i = 0; i < nbeats; i++) begin
      repeat (gap) begin rvalid = 0; tick(); end
      rvalid = 1;
      rdata  = base + i;
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == last_at);
      rid    = exp_id;
      tick();
    end
    rvalid = 0;
    rlast  = 0;
  endtask

  task automatic slave_write(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] strb,
                             input logic [31:0] wd, input logic [1:0] resp, input bit delay_w);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (awvalid) seen = 1;
      else tick();
    end
    if (!seen) begin
      checkOutput("awvalid_timeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("awaddr", awaddr, addr);
    checkOutput("awsize_len_id", {awsize, awlen, awid}, {size, 8'd0, 4'h1});
    checkOutput("wvalid_wlast", {wvalid, wlast}, 2'b11);
    checkOutput("wstrb", wstrb, strb);
    checkOutput("wdata", wdata, wd);
    tick();
    if (delay_w) begin
      wready = 1;
      @(negedge clock);
      checkOutput("aw_drops_w_holds", {awvalid, wvalid}, 2'b01);
      tick();
    end
    bvalid = 1; bresp = resp; bid = 4'h1;
    @(negedge clock);
    checkOutput("bready", bready, 1'b1);
    tick();
    bvalid = 0;
  endtask

  task automatic ifu_burst(input logic [31:0] addr, input logic [7:0] len_req, input int gap,
                           input logic [31:0] base, input int err_beat, input int last_at);
    int   acc;
    int   eff;
    exp_t e;
    eff = (len_req > 8'd15) ? 15 : int'(len_req);
    for (int i = 0; i <= eff; i++) begin
      e.data = base + i; e.last = (i == eff); e.chk_data = 1; e.cyc = -1;
      e.err = (i == err_beat) || ((i == eff) != (i == last_at));
      ifu_q.push_back(e);
    end
    applyStimulus(1'b0, 1'b0, addr, len_req, 3'd0, 32'h0, acc);
    slave_read(eff + 1, gap, base, err_beat, last_at, addr, 8'(eff), 3'd2, 4'h0);
  endtask

  task automatic lsu_load(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] bus,
                          input logic [31:0] exp, input bit chk_lat);
    int   acc;
    exp_t e;
    applyStimulus(1'b1, 1'b0, addr, 8'd0, size, 32'h0, acc);
    e.data = exp; e.last = 0; e.err = 0; e.chk_data = 1; e.cyc = chk_lat ? acc + 3 : -1;
    lsu_q.push_back(e);
    slave_read(1, 1, bus, -1, 0, addr, 8'd0, size, 4'h1);
  endtask

  task automatic lsu_store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [31:0] bus_wd,
                           input logic [1:0] resp, input bit delay_w);
    int   acc;
    exp_t e;
    if (delay_w) wready = 0;
    applyStimulus(1'b1, 1'b1, addr, 8'd0, size, wd, acc);
    e.data = 0; e.last = 0; e.err = (resp != 2'b00); e.chk_data = 0; e.cyc = -1;
    lsu_q.push_back(e);
    slave_write(addr, size, strb, bus_wd, resp, delay_w);
  endtask

  initial begin
    int   acc;
    exp_t e;
    logic [1:0] exp_grant [2];
`ifdef ARB_RR_EN
    exp_grant[0] = 2'b10; exp_grant[1] = 2'b01;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b01;
`endif
    reset = 1;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_req_len = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_size = 0; lsu_req_wdata = 0;
    awready = 1; wready = 1; arready = 1;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    repeat (3) tick();
    @(negedge clock);
    checkOutput("reset_outputs_low",
                {ifu_req_ready, lsu_req_ready, arvalid, awvalid, wvalid, rready, bready,
                 ifu_rsp_valid, lsu_rsp_valid}, 9'd0);
    tick();
    reset = 0;
    @(negedge clock);
    checkOutput("idle_ready_after_reset", {ifu_req_ready, lsu_req_ready}, 2'b11);
    tick();

    $display("[TB] arbitration with simultaneous requests");
    for (int r = 0; r < 2; r++) begin
      ifu_req_valid = 1; ifu_req_addr = 32'h3000_0040; ifu_req_len = 0;
      lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0008; lsu_req_size = 2;
      @(negedge clock);
      checkOutput("arb_grant", {ifu_req_ready, lsu_req_ready}, exp_grant[r]);
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      e.last = 1; e.err = 0; e.chk_data = 1; e.cyc = -1;
      if (exp_grant[r] == 2'b10) begin
        e.data = 32'hA000_0000 + r;
        ifu_q.push_back(e);
        slave_read(1, 0, 32'hA000_0000 + r, -1, 0, 32'h3000_0040, 8'd0, 3'd2, 4'h0);
      end else begin
        e.data = 32'h55AA_0000 + r; e.last = 0;
        lsu_q.push_back(e);
        slave_read(1, 0, 32'h55AA_0000 + r, -1, 0, 32'h8000_0008, 8'd0, 3'd2, 4'h1);
      end
      tick();
    end

    $display("[TB] LSU loads and stores");
    lsu_load(32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    lsu_load(32'h8000_0002, 3'd0, 32'h1122_3344, 32'h0000_1122, 1'b0);
    lsu_store(32'h8000_0003, 3'd0, 32'h0000_00AB, 4'b1000, 32'hAB00_0000, 2'b00, 1'b1);
    lsu_store(32'h8000_0010, 3'd2, 32'h1234_5678, 4'b1111, 32'h1234_5678, 2'b11, 1'b0);

    $display("[TB] misaligned halfword load");
    applyStimulus(1'b1, 1'b0, 32'h8000_0001, 8'd0, 3'd1, 32'h0, acc);
    e.data = 0; e.last = 0; e.err = 1; e.chk_data = 0; e.cyc = acc + 1;
    lsu_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("misaligned_no_bus", {arvalid, awvalid}, 2'b00);
      tick();
    end

    $display("[TB] IFU bursts");
    ifu_burst(32'h3000_0000, 8'd3, 2, 32'hC0DE_0000, -1, 3);
    ifu_burst(32'h3000_0010, 8'd3, 0, 32'h1111_0000, 1, 3);
    ifu_burst(32'h3000_0020, 8'd1, 0, 32'h2222_0000, -1, 0);
    ifu_burst(32'h3000_0040, 8'd20, 0, 32'h3333_0000, -1, 15);

    $display("[TB] reset during read data phase");
    applyStimulus(1'b0, 1'b0, 32'h3000_0100, 8'd3, 3'd0, 32'h0, acc);
    e.data = 32'h4444_0000; e.last = 0; e.err = 0; e.chk_data = 1; e.cyc = -1;
    ifu_q.push_back(e);
    slave_read(1, 0, 32'h4444_0000, -1, 3, 32'h3000_0100, 8'd3, 3'd2, 4'h0);
    reset = 1;
    #2;
    checkOutput("reset_mid_outputs_low",
                {arvalid, rready, ifu_req_ready, lsu_req_ready, awvalid, wvalid, bready}, 7'd0);
    tick();
    reset = 0;
    @(negedge clock);
    checkOutput("idle_after_mid_reset", {arvalid, ifu_req_ready}, 2'b01);
    tick();
    lsu_load(32'h8000_0020, 3'd1, 32'hBEEF_CAFE, 32'hBEEF_CAFE, 1'b1);

    repeat (5) tick();
    checkOutput("ifu_queue_drained", ifu_q.size(), 0);
    checkOutput("lsu_queue_drained", lsu_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
